// File: rtl/hull_fifo_pkg.sv
// hull_fifo_pkg
//   Shared constants for the hull_fifo buffering primitive.
//   FIFO_SHOWAHEAD : q presents the head word combinationally (first-word-fall-through).
//   FIFO_NORMAL    : q is registered and loads the head word on an accepted read.
//   Any TYPE value other than FIFO_SHOWAHEAD behaves as FIFO_NORMAL.
package hull_fifo_pkg;

  localparam int FIFO_SHOWAHEAD = 0;
  localparam int FIFO_NORMAL    = 1;

endpackage : hull_fifo_pkg

// File: rtl/hull_fifo_ram.sv
// hull_fifo_ram
//   Simple dual-port storage array for hull_fifo: one synchronous write port
//   and one asynchronous read port. The contents are never reset.
// Ports:
//   clock   in   write clock
//   we      in   write enable
//   waddr   in   write address (LOG_DEPTH bits)
//   wdata   in   write data (WIDTH bits)
//   raddr   in   read address (LOG_DEPTH bits)
//   rdata   out  word at raddr, combinational
module hull_fifo_ram #(
  parameter int WIDTH     = 64,
  parameter int LOG_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [LOG_DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [LOG_DEPTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // The show-ahead mode needs the head word visible without waiting an edge.
  assign rdata = mem_reg[raddr];

endmodule : hull_fifo_ram

// File: rtl/hull_fifo.sv
// hull_fifo
//   Single-clock synchronous FIFO with selectable read mode.
//   TYPE == FIFO_SHOWAHEAD : q = head word whenever empty=0; rdreq pops it.
//   otherwise              : q is a register loaded with the head word on an
//                            accepted read (1-cycle latency) and held otherwise.
//   Writes while full and reads while empty are dropped without side effects.
// Ports:
//   clock    in   sole clock, rising edge
//   reset_n  in   asynchronous active-low reset; discards all contents
//   wrreq    in   write request
//   data     in   write data (WIDTH bits)
//   full     out  FIFO holds DEPTH entries
//   rdreq    in   read/pop request
//   q        out  read data (WIDTH bits)
//   empty    out  FIFO holds no entries
module hull_fifo
  import hull_fifo_pkg::*;
#(
  parameter int TYPE      = FIFO_SHOWAHEAD,
  parameter int WIDTH     = 64,
  parameter int LOG_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             empty
);

  localparam int                   DEPTH      = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]   COUNT_FULL = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   COUNT_ONE  = (LOG_DEPTH + 1)'(1);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE    = LOG_DEPTH'(1);

  logic [LOG_DEPTH-1:0] wrptr_reg, wrptr_next;
  logic [LOG_DEPTH-1:0] rdptr_reg, rdptr_next;
  logic [LOG_DEPTH:0]   count_reg, count_next;
  logic                 wr_ok;
  logic                 rd_ok;
  logic [WIDTH-1:0]     head_word;

  // Flags come from the registered count only, so a simultaneous read
  // cannot make room for a write in the same cycle (and vice versa).
  assign full  = (count_reg == COUNT_FULL);
  assign empty = (count_reg == '0);

  assign wr_ok = wrreq & ~full;
  assign rd_ok = rdreq & ~empty;

  always_comb begin
    wrptr_next = wrptr_reg;
    rdptr_next = rdptr_reg;
    count_next = count_reg;
    if (wr_ok) begin
      wrptr_next = wrptr_reg + PTR_ONE;
    end
    if (rd_ok) begin
      rdptr_next = rdptr_reg + PTR_ONE;
    end
    // Pointers wrap naturally modulo DEPTH; only the count needs the extra bit.
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + COUNT_ONE;
      2'b01:   count_next = count_reg - COUNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrptr_reg <= '0;
      rdptr_reg <= '0;
      count_reg <= '0;
    end else begin
      wrptr_reg <= wrptr_next;
      rdptr_reg <= rdptr_next;
      count_reg <= count_next;
    end
  end

  hull_fifo_ram #(
    .WIDTH     (WIDTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (wr_ok),
    .waddr (wrptr_reg),
    .wdata (data),
    .raddr (rdptr_reg),
    .rdata (head_word)
  );

  generate
    if (TYPE == FIFO_SHOWAHEAD) begin : g_showahead
      // Head word is stale/don't-care while empty; consumers gate on empty.
      assign q = head_word;
    end else begin : g_normal
      logic [WIDTH-1:0] q_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          q_reg <= '0;
        end else if (rd_ok) begin
          q_reg <= head_word;
        end
      end

      assign q = q_reg;
    end
  endgenerate

endmodule : hull_fifo

// File: tb/tb_hull_fifo.sv
// tb_hull_fifo
//   Drives one show-ahead and one normal-mode hull_fifo with identical
//   directed stimulus. Expected read data is pushed into per-instance queues
//   by the stimulus; a monitor on the falling edge pops and compares whenever
//   an instance accepts a read (show-ahead: same cycle; normal: next cycle).
module tb_hull_fifo;

  localparam int W = 64;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         wrreq;
  logic [W-1:0] data;
  logic         rdreq;
  logic         full_sa, empty_sa, full_nm, empty_nm;
  logic [W-1:0] q_sa, q_nm;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_sa[$];
  logic [W-1:0] exp_nm[$];
  logic         nm_pending = 1'b0;

  always #5 clock = ~clock;

  hull_fifo #(.TYPE(0), .WIDTH(W), .LOG_DEPTH(4)) u_sa (
    .clock   (clock),
    .reset_n (reset_n),
    .wrreq   (wrreq),
    .data    (data),
    .full    (full_sa),
    .rdreq   (rdreq),
    .q       (q_sa),
    .empty   (empty_sa)
  );

  hull_fifo #(.TYPE(1), .WIDTH(W), .LOG_DEPTH(4)) u_nm (
    .clock   (clock),
    .reset_n (reset_n),
    .wrreq   (wrreq),
    .data    (data),
    .full    (full_nm),
    .rdreq   (rdreq),
    .q       (q_nm),
    .empty   (empty_nm)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_flags(input string name, input logic e, input logic f);
    check({name, " empty_sa"}, W'(empty_sa), W'(e));
    check({name, " full_sa"},  W'(full_sa),  W'(f));
    check({name, " empty_nm"}, W'(empty_nm), W'(e));
    check({name, " full_nm"},  W'(full_nm),  W'(f));
  endtask

  task automatic push_exp(input logic [W-1:0] v);
    exp_sa.push_back(v);
    exp_nm.push_back(v);
  endtask

  // Inputs change 1 time unit after a rising edge and are held for one cycle.
  task automatic drive(input logic wr, input logic [W-1:0] d, input logic rd);
    @(posedge clock);
    #1;
    wrreq = wr;
    data  = d;
    rdreq = rd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0);
  endtask

  // Scoreboard monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      nm_pending = 1'b0;
    end else begin
      if (nm_pending) begin
        if (exp_nm.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL nm_read: got %h expected <no pending data>", q_nm);
        end else begin
          check("nm_read", q_nm, exp_nm.pop_front());
        end
      end
      nm_pending = rdreq && !empty_nm;
      if (rdreq && !empty_sa) begin
        if (exp_sa.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sa_read: got %h expected <no pending data>", q_sa);
        end else begin
          check("sa_read", q_sa, exp_sa.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    wrreq   = 1'b0;
    rdreq   = 1'b0;
    data    = '0;
    repeat (2) @(posedge clock);
    #1;
    check_flags("por", 1'b1, 1'b0);
    check("por q_nm", q_nm, '0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Reset mid-stream with 5 entries held.
    for (int i = 1; i <= 5; i++) drive(1'b1, W'(64'h50 + i), 1'b0);
    idle();
    check_flags("five_held", 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check_flags("async_rst", 1'b1, 1'b0);
    check("async_rst q_nm", q_nm, '0);
    exp_sa.delete();
    exp_nm.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 64'hA, 1'b0);
    push_exp(64'hA);
    drive(1'b0, '0, 1'b1);
    idle();
    check_flags("post_rst", 1'b1, 1'b0);

    // Fill with 1..17: the 17th is dropped.
    for (int i = 1; i <= 17; i++) drive(1'b1, W'(i), 1'b0);
    check_flags("after16", 1'b0, 1'b1);
    idle();
    check_flags("after17", 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) push_exp(W'(i));
    for (int i = 1; i <= 16; i++) drive(1'b0, '0, 1'b1);
    idle();
    check_flags("drained", 1'b1, 1'b0);

    // Show-ahead: word appears the cycle after the write without rdreq.
    drive(1'b1, 64'h55, 1'b0);
    idle();
    check_flags("sa_one", 1'b0, 1'b0);
    check("sa_fallthrough", q_sa, 64'h55);
    push_exp(64'h55);
    drive(1'b0, '0, 1'b1);
    idle();
    check_flags("sa_popped", 1'b1, 1'b0);

    // Normal mode latency and hold.
    drive(1'b1, 64'h7, 1'b0);
    drive(1'b1, 64'h8, 1'b0);
    push_exp(64'h7);
    push_exp(64'h8);
    drive(1'b0, '0, 1'b1);
    idle();
    check("nm_q7", q_nm, 64'h7);
    repeat (3) idle();
    check("nm_hold7", q_nm, 64'h7);
    drive(1'b0, '0, 1'b1);
    idle();
    check("nm_q8", q_nm, 64'h8);

    // Underflow: reads while empty are ignored, q_nm holds.
    repeat (3) drive(1'b0, '0, 1'b1);
    idle();
    check_flags("underflow", 1'b1, 1'b0);
    check("underflow q_nm", q_nm, 64'h8);
    drive(1'b1, 64'h33, 1'b0);
    push_exp(64'h33);
    drive(1'b0, '0, 1'b1);
    idle();
    check_flags("uf_recover", 1'b1, 1'b0);

    // Simultaneous read+write while empty: only the write takes.
    drive(1'b1, 64'h77, 1'b1);
    idle();
    check_flags("both_empty", 1'b0, 1'b0);
    push_exp(64'h77);
    drive(1'b0, '0, 1'b1);
    idle();
    check_flags("both_empty_drain", 1'b1, 1'b0);

    // Simultaneous read+write while full: head popped, write dropped.
    for (int i = 1; i <= 16; i++) drive(1'b1, W'(64'h100 + i), 1'b0);
    idle();
    check_flags("full_again", 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) push_exp(W'(64'h100 + i));
    drive(1'b1, 64'hDEAD, 1'b1);
    idle();
    check_flags("both_full", 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) drive(1'b0, '0, 1'b1);
    idle();
    check_flags("both_full_drain", 1'b1, 1'b0);

    // Half full, 20 cycles of simultaneous ops across pointer wrap.
    for (int i = 0; i < 8; i++) drive(1'b1, W'(64'h200 + i), 1'b0);
    for (int i = 0; i < 28; i++) push_exp(W'(64'h200 + i));
    for (int i = 8; i < 28; i++) drive(1'b1, W'(64'h200 + i), 1'b1);
    idle();
    check_flags("half_steady", 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, '0, 1'b1);
    idle();
    check_flags("half_one_left", 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1);
    idle();
    check_flags("half_drained", 1'b1, 1'b0);

    repeat (3) idle();
    check("sa_queue_left", W'(exp_sa.size()), '0);
    check("nm_queue_left", W'(exp_nm.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_hull_fifo

// File: doc/hull_fifo.md
Name: hull_fifo

Overview:
- Parameterised single-clock synchronous FIFO used as the general buffering primitive in the PageRank accelerator, e.g. the 16-entry, 64-bit vertex queue between the memory read buffer and the PageRank datapath.
- Supports two read modes selected by TYPE: show-ahead (first-word-fall-through) and normal registered read.
- Provides full/empty status and ignores writes when full and reads when empty.

Parameters:
- TYPE, default 0: read mode. 0 = show-ahead (q presents the head word while not empty; rdreq pops it). Any nonzero value = normal mode (q loads the head word on the clock edge that accepts rdreq).
- WIDTH, default 64: data word width in bits.
- LOG_DEPTH, default 4: log2 of capacity; DEPTH = 2**LOG_DEPTH entries.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wrreq  input  1  write request; accepted only when full=0.
- data  input  WIDTH  write data, captured on an accepted write.
- full  output  1  1 when the FIFO holds DEPTH entries.
- rdreq  input  1  read/pop request; accepted only when empty=0.
- q  output  WIDTH  read data (meaning depends on TYPE).
- empty  output  1  1 when the FIFO holds 0 entries.

Behaviour:
- Storage: DEPTH x WIDTH array, not reset.
- State: write pointer and read pointer, LOG_DEPTH bits each, wrapping modulo DEPTH; occupancy count, LOG_DEPTH+1 bits.
- Reset (reset_n=0, asynchronous, takes effect immediately):
  - pointers and count = 0
  - empty = 1, full = 0
  - registered q (TYPE!=0) = 0
- Reset mid-operation discards all contents; the first write after release is the new head.
- Status flags: full = (count == DEPTH); empty = (count == 0). Both are decoded from registered count, so they reflect state after the last edge.
- Write accept: wr_ok = wrreq & !full.
  - On wr_ok: mem[wrptr] <= data, wrptr increments.
  - A write while full is silently dropped; no state changes.
- Read accept: rd_ok = rdreq & !empty.
  - On rd_ok: rdptr increments.
  - A read while empty is ignored; q and pointers are unchanged.
- Count update:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged when both or neither are accepted.
- Simultaneous read and write:
  - When full: the read is accepted, the write is dropped (flags are evaluated on pre-edge state). Count goes DEPTH-1.
  - When empty: the write is accepted, the read is ignored. Count goes 1.
  - When partially full: both are accepted and count holds.
- TYPE 0 (show-ahead):
  - q = mem[rdptr] combinationally, valid whenever empty=0.
  - A word written into an empty FIFO appears on q the cycle after the write edge, when empty deasserts.
  - Consumers may sample q in the same cycle they assert rdreq.
  - q is don't-care when empty=1.
- TYPE nonzero (normal):
  - On rd_ok, q <= mem[rdptr], giving 1-cycle read latency.
  - q holds its value otherwise, including when empty.
- Ordering: strict FIFO order; wrap-around of the pointers is transparent.

Decomposition:
- No shared package is required.
- Optionally place the mode encodings (FIFO_SHOWAHEAD=0, FIFO_NORMAL=1) in the project constants include.
- Single module; the memory array may be a separate inferred-RAM sub-module, hull_fifo_ram (simple dual-port, one write port, async read for TYPE 0), but inline is acceptable.

Test Plan:
- Reset: assert reset_n=0 mid-stream with 5 entries held, release -> empty=1, full=0 immediately; next write 0xA followed by a read returns 0xA.
- Fill/overflow (TYPE 0, LOG_DEPTH=4): write 1..17 on consecutive cycles -> full=1 after the 16th write; the 17th is dropped; reading 16 times gives 1..16, then empty=1.
- Show-ahead timing: write 0x55 into the empty FIFO -> next cycle empty=0 and q=0x55 with no rdreq; rdreq that cycle -> empty=1 the next cycle.
- Normal mode (TYPE=1): write 7, 8; rdreq for one cycle -> q=7 after that edge; q holds 7 until the next rdreq, which yields 8.
- Underflow: rdreq while empty for 3 cycles -> no change; the count stays 0 and a subsequent write/read returns the correct data.
- Simultaneous ops:
  - Full + wrreq + rdreq -> count 15, full=0, head popped, new data not stored.
  - Half-full (8 entries) with both requests for 20 cycles -> count stays 8; output order is preserved across pointer wrap.
